bus_transfer_driver: RTL and testbench
======================================

# bus_transfer_driver

Bus-side transmitter for the datapath's shared internal bus. Accepts queued transfer commands: which source byte to place on the bus, and which destination registers capture it. Each command is issued as one registered bus cycle, driving the bus value and a one-hot-per-destination read-enable vector into the registers' bus input ports. Sits between the control sequencer and the register file. It replaces ad-hoc enable generation with a buffered, stallable transfer stream.

## Interface
Parameters:
- SOURCE_COUNT, 4, number of byte sources selectable onto the bus
- DEST_COUNT, 4, number of destination registers (width of busReadEnable)
- WIDTH, 8, bus width in bits
- FIFO_DEPTH, 4, command buffer entries (power of two, ≥2)
- IDLE_VALUE, {WIDTH{1'b0}}, value driven on busValue when no transfer is issued

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- sourceBytes  in  WIDTH*SOURCE_COUNT  packed sources; source i at [WIDTH*(i+1)-1:WIDTH*i]
- cmdValid  in  1  command present
- cmdReady  out  1  driver can accept a command this cycle
- cmdSource  in  max(1,$clog2(SOURCE_COUNT))  source index
- cmdDestMask  in  DEST_COUNT  destinations to load; multiple bits allowed
- stall  in  1  hold: no issue this cycle
- busValue  out  WIDTH  registered bus byte
- busReadEnable  out  DEST_COUNT  registered destination enables
- busy  out  1  FIFO non-empty or transfer on bus
- cmdError  out  1  one-cycle pulse: command rejected, bad source index

## Operation
- Handshake: command accepted on a posedge where cmdValid && cmdReady.
- cmdReady = (count < FIFO_DEPTH) && !rst. Driven from registered count only; no combinational path from cmdValid or stall.
- A push is refused when full, even if a pop occurs in the same cycle.
- Accepted command with cmdSource ≥ SOURCE_COUNT: not enqueued; cmdError pulses high for the cycle after acceptance.
- FIFO: circular buffer with read/write pointers and count. Push and pop in the same cycle leave count unchanged.
- Issue (each posedge, !rst):
  - If FIFO non-empty and !stall: pop head. busValue <= sourceBytes slice[head.source], sampled at that edge. busReadEnable <= head.destMask.
  - Otherwise: busValue <= IDLE_VALUE, busReadEnable <= 0.
- A zero destMask is a legal no-op. It consumes one issue slot and drives busValue with enables 0.
- Commands issue strictly in acceptance order, at most one per cycle.
- busy = (count != 0) || (|busReadEnable).

## Timing
- Reset values: busValue = IDLE_VALUE, busReadEnable = 0, cmdError = 0, busy = 0, count = 0, pointers = 0. cmdReady = 0 while rst is high, 1 the cycle after release.
- Latency: command accepted at edge E0 → enables visible in the cycle after E1 (one cycle) → destinations capture at E2.
- Back-to-back: with stall low, a continuous command stream issues one transfer per cycle at full throughput.
- Each issued enable vector is high for exactly one cycle.
- Stall: while stall is high, no pop and outputs idle. The entry is issued at the first edge with stall low.
- rst mid-operation: FIFO flushed, queued commands discarded, outputs idle at the next edge.
- Pointer wrap-around at FIFO_DEPTH is transparent; ordering is preserved.

## Configuration
- BUS_TRANSFER_COUNT_EN:
  - Defined: adds output transferCount [15:0]. It increments by 1 on every issued transfer with a nonzero destMask, wraps 0xFFFF→0x0000, and resets to 0.
  - Undefined: no port and no counter logic; all other behaviour identical.

## Test plan
- Reset then single command {src=2, mask=4'b0101}, sourceBytes[2]=8'hA5 → one cycle later busValue=8'hA5, busReadEnable=4'b0101 for exactly one cycle, then IDLE_VALUE/0.
- Five back-to-back commands, stall low, no pops blocked → cmdReady stays high, 5 consecutive issue cycles, correct order; busy falls after the last.
- Hold stall high, push 4 commands → cmdReady low on 5th attempt. Release stall → 4 issues in order, cmdReady high one cycle after first pop.
- SOURCE_COUNT=3, cmdSource=3 → cmdError pulses one cycle, nothing issued, count unchanged.
- Assert rst with 3 queued and one on bus → next cycle all outputs idle, busy=0. After release, a new command issues normally.
- With BUS_TRANSFER_COUNT_EN: preload near wrap, issue a mix of zero-mask and nonzero-mask commands → only nonzero masks count; 0xFFFF→0x0000.

Source files
------------

// File: rtl/bus_transfer_driver.sv
// Buffered bus transmitter: queued {source, destMask} commands become one registered bus cycle each.
// Optional BUS_TRANSFER_COUNT_EN adds transferCount, counting issued transfers with a nonzero mask.
module bus_transfer_driver #(
  parameter int SOURCE_COUNT = 4,
  parameter int DEST_COUNT = 4,
  parameter int WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}},
  localparam int SRC_W = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*SOURCE_COUNT-1:0] sourceBytes,
  input  logic                      cmdValid,
  output logic                      cmdReady,
  input  logic [SRC_W-1:0]          cmdSource,
  input  logic [DEST_COUNT-1:0]     cmdDestMask,
  input  logic                      stall,
  output logic [WIDTH-1:0]          busValue,
  output logic [DEST_COUNT-1:0]     busReadEnable,
  output logic                      busy,
  output logic                      cmdError
`ifdef BUS_TRANSFER_COUNT_EN
  ,
  output logic [15:0]               transferCount
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W:0] SRC_LIMIT = (SRC_W + 1)'(SOURCE_COUNT);

  logic [SRC_W-1:0]      src_mem  [FIFO_DEPTH];
  logic [DEST_COUNT-1:0] mask_mem [FIFO_DEPTH];
  logic [WIDTH-1:0]      src_array [SOURCE_COUNT];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push_fire, src_ok, push, pop;
  logic [SRC_W-1:0]      head_src;
  logic [DEST_COUNT-1:0] head_mask;
  logic [WIDTH-1:0]      head_byte;

  genvar gi;
  generate
    for (gi = 0; gi < SOURCE_COUNT; gi++) begin : g_src
      assign src_array[gi] = sourceBytes[WIDTH*(gi+1)-1 : WIDTH*gi];
    end
  endgenerate

  // Ready depends only on registered occupancy, so a full FIFO refuses a push even when popping.
  assign cmdReady  = (count_reg < DEPTH_CNT) && !rst;
  assign push_fire = cmdValid && cmdReady;
  assign src_ok    = {1'b0, cmdSource} < SRC_LIMIT;
  assign push      = push_fire && src_ok;
  assign pop       = (count_reg != '0) && !stall;
  assign head_src  = src_mem[rd_ptr_reg];
  assign head_mask = mask_mem[rd_ptr_reg];
  assign busy      = (count_reg != '0) || (|busReadEnable);

  always_comb begin
    head_byte = IDLE_VALUE;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      if (head_src == SRC_W'(i)) head_byte = src_array[i];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_reg]  <= cmdSource;
      mask_mem[wr_ptr_reg] <= cmdDestMask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      cmdError      <= 1'b0;
      busValue      <= IDLE_VALUE;
      busReadEnable <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      cmdError  <= push_fire && !src_ok;
      if (pop) begin
        busValue      <= head_byte;
        busReadEnable <= head_mask;
      end else begin
        busValue      <= IDLE_VALUE;
        busReadEnable <= '0;
      end
    end
  end

`ifdef BUS_TRANSFER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      transferCount <= 16'h0000;
    end else if (pop && (head_mask != '0)) begin
      transferCount <= transferCount + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_bus_transfer_driver.sv
// Bench for bus_transfer_driver: directed scenarios then random traffic against a queue-based model.
module tb_bus_transfer_driver;
  localparam int SC = 3;
  localparam int DC = 4;
  localparam int W  = 8;
  localparam int FD = 4;
  localparam logic [W-1:0] IDLE = 8'h3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W*SC-1:0] sourceBytes = '0;
  logic cmdValid = 1'b0;
  logic cmdReady;
  logic [1:0] cmdSource = '0;
  logic [DC-1:0] cmdDestMask = '0;
  logic stall = 1'b0;
  logic [W-1:0] busValue;
  logic [DC-1:0] busReadEnable;
  logic busy;
  logic cmdError;
`ifdef BUS_TRANSFER_COUNT_EN
  logic [15:0] transferCount;
`endif

  bus_transfer_driver #(
    .SOURCE_COUNT(SC), .DEST_COUNT(DC), .WIDTH(W), .FIFO_DEPTH(FD), .IDLE_VALUE(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .sourceBytes(sourceBytes), .cmdValid(cmdValid),
    .cmdReady(cmdReady), .cmdSource(cmdSource), .cmdDestMask(cmdDestMask),
    .stall(stall), .busValue(busValue), .busReadEnable(busReadEnable),
    .busy(busy), .cmdError(cmdError)
`ifdef BUS_TRANSFER_COUNT_EN
    , .transferCount(transferCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [DC-1:0] mask;
  } cmd_t;

  cmd_t q[$];
  logic [W-1:0]  exp_bus = IDLE;
  logic [DC-1:0] exp_en  = '0;
  logic [15:0]   exp_cnt = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock: predict from current inputs, let the edge happen, then compare.
  task automatic cycle();
    logic [W-1:0]  nb;
    logic [DC-1:0] ne;
    logic          nerr;
    logic          acc;
    cmd_t          h;
    nb = IDLE;
    ne = '0;
    nerr = 1'b0;
    if (rst) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      acc = cmdValid && (q.size() < FD);
      if (q.size() != 0 && !stall) begin
        h = q.pop_front();
        nb = sourceBytes[W*h.src +: W];
        ne = h.mask;
        if (h.mask != '0) exp_cnt = exp_cnt + 16'd1;
      end
      if (acc) begin
        if (cmdSource < SC) q.push_back({cmdSource, cmdDestMask});
        else nerr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_bus = nb;
    exp_en = ne;
    chk("busValue", 32'(busValue), 32'(exp_bus));
    chk("busReadEnable", 32'(busReadEnable), 32'(exp_en));
    chk("cmdError", 32'(cmdError), 32'(nerr));
    chk("busy", 32'(busy), 32'((q.size() != 0) || (exp_en != '0)));
    chk("cmdReady", 32'(cmdReady), 32'((q.size() < FD) && !rst));
`ifdef BUS_TRANSFER_COUNT_EN
    chk("transferCount", 32'(transferCount), 32'(exp_cnt));
`endif
    $display("cycle %0d rst=%0b v=%0b src=%0d mask=%b stall=%0b -> bus=%h en=%b err=%0b busy=%0b rdy=%0b",
             cyc, rst, cmdValid, cmdSource, cmdDestMask, stall, busValue, busReadEnable,
             cmdError, busy, cmdReady);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [DC-1:0] m);
    cmdValid = v;
    cmdSource = s;
    cmdDestMask = m;
  endtask

  initial begin
    sourceBytes = {8'hA5, 8'h77, 8'h12};
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single command from source 2
    drive(1'b1, 2'd2, 4'b0101);
    cycle();
    drive(1'b0, 2'd0, 4'b0000);
    cycle();
    cycle();

    // Five back-to-back commands, including a zero-mask no-op
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 3), 4'(i + 1) & ((i == 3) ? 4'b0000 : 4'b1111));
      sourceBytes = {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
      cycle();
    end
    drive(1'b0, 2'd0, 4'b0000);
    for (int i = 0; i < 3; i++) cycle();

    // Fill under stall; fifth attempt is refused
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(2 - (i % 3)), 4'(4'b1000 >> (i % 4)));
      cycle();
    end
    drive(1'b0, 2'd0, 4'b0000);
    cycle();
    stall = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // Out-of-range source index
    drive(1'b1, 2'd3, 4'b1111);
    cycle();
    drive(1'b0, 2'd0, 4'b0000);
    cycle();
    cycle();

    // Reset with three queued and one on the bus
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i % 3), 4'b0011);
      cycle();
    end
    drive(1'b0, 2'd0, 4'b0000);
    stall = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    drive(1'b1, 2'd1, 4'b1001);
    cycle();
    drive(1'b0, 2'd0, 4'b0000);
    cycle();
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom));
      stall = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 63) == 0);
      sourceBytes = 24'($urandom);
      cycle();
    end
    rst = 1'b0;
    stall = 1'b0;
    drive(1'b0, 2'd0, 4'b0000);
    for (int i = 0; i < 6; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
